// File: rtl/env_pkg.sv
// Shared types and constants for the ADSR envelope scheduler.
package env_pkg;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_ATTACK,
    PH_DECAY_SUS,
    PH_RELEASE
  } env_phase_e;

  localparam int unsigned RATE_CNT_W = 11;

  // Sample ticks per one-level envelope step, indexed by the 4-bit rate field.
  localparam logic [RATE_CNT_W-1:0] RATE_LUT [16] = '{
    11'd1,   11'd2,   11'd4,    11'd6,    11'd9,    11'd14,   11'd17,   11'd20,
    11'd25,  11'd62,  11'd125,  11'd200,  11'd250,  11'd750,  11'd1250, 11'd2000
  };

  function automatic logic [7:0] sustain_level(input logic [3:0] s);
    return {4'b0000, s} * 8'd17;
  endfunction

endpackage

// File: rtl/env_step.sv
// Combinational envelope next-state for one voice; shared by all voices in turn.
module env_step
  import env_pkg::*;
(
  input  logic                  gate,
  input  logic                  prev_gate,
  input  env_phase_e            phase,
  input  logic [RATE_CNT_W-1:0] cnt,
  input  logic [7:0]            level,
  input  logic [7:0]            ad,
  input  logic [7:0]            sr,
  output env_phase_e            phase_next,
  output logic [RATE_CNT_W-1:0] cnt_next,
  output logic [7:0]            level_next
);

  logic                  rise;
  logic                  fall;
  logic [3:0]            rate;
  logic [RATE_CNT_W-1:0] period;
  logic                  hit;

  always_comb begin
    phase_next = phase;
    cnt_next   = cnt;
    level_next = level;
    rise       = gate & ~prev_gate;
    fall       = ~gate & prev_gate;

    unique case (phase)
      PH_ATTACK:    rate = ad[7:4];
      PH_DECAY_SUS: rate = ad[3:0];
      PH_RELEASE:   rate = sr[3:0];
      default:      rate = 4'h0;
    endcase
    period = RATE_LUT[rate];
    // Counter may exceed a newly shortened period; >= catches that on the next slot.
    hit = ({1'b0, cnt} + 12'd1) >= {1'b0, period};

    if (rise) begin
      phase_next = PH_ATTACK;
      cnt_next   = '0;
    end else if (fall && (phase == PH_ATTACK || phase == PH_DECAY_SUS)) begin
      phase_next = PH_RELEASE;
      cnt_next   = '0;
    end else if (phase == PH_IDLE) begin
      cnt_next = '0;
    end else if (!hit) begin
      cnt_next = cnt + 1'b1;
    end else begin
      cnt_next = '0;
      unique case (phase)
        PH_ATTACK: begin
          if (level >= 8'hFE) begin
            level_next = '1;
            phase_next = PH_DECAY_SUS;
          end else begin
            level_next = level + 8'd1;
          end
        end
        PH_DECAY_SUS: begin
          if (level > sustain_level(sr[7:4])) level_next = level - 8'd1;
        end
        PH_RELEASE: begin
          if (level <= 8'd1) begin
            level_next = '0;
            phase_next = PH_IDLE;
          end else begin
            level_next = level - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/adsr_scheduler.sv
// Per-sample sweep over all voices, time-sharing one env_step unit (load slot, then update slot).
module adsr_scheduler
  import env_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    sample_tick_i,
  input  logic [NUM_VOICES*8-1:0] control_i,
  input  logic [NUM_VOICES*8-1:0] ad_i,
  input  logic [NUM_VOICES*8-1:0] sr_i,
  output logic [NUM_VOICES*8-1:0] env_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    overrun_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_UPDATE} sweep_state_e;

  sweep_state_e state_q, state_d;
  logic [3:0]   voice_q, voice_d;
  logic         last_voice;

  env_phase_e            phase_q     [NUM_VOICES];
  logic [RATE_CNT_W-1:0] cnt_q       [NUM_VOICES];
  logic [7:0]            level_q     [NUM_VOICES];
  logic                  prev_gate_q [NUM_VOICES];

  logic                  sel_gate, sel_prev;
  env_phase_e            sel_phase;
  logic [RATE_CNT_W-1:0] sel_cnt;
  logic [7:0]            sel_level, sel_ad, sel_sr;

  logic                  stg_gate, stg_prev;
  env_phase_e            stg_phase;
  logic [RATE_CNT_W-1:0] stg_cnt;
  logic [7:0]            stg_level, stg_ad, stg_sr;

  env_phase_e            nxt_phase;
  logic [RATE_CNT_W-1:0] nxt_cnt;
  logic [7:0]            nxt_level;

  // Only the gate bit is consumed here; the rest of the control byte serves other blocks.
  logic ctrl_unused;
  always_comb begin
    ctrl_unused = 1'b0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) ctrl_unused ^= ^control_i[i*8+1 +: 7];
  end

  assign last_voice = (voice_q == 4'(NUM_VOICES - 1));
  assign busy_o     = (state_q != S_IDLE);
  assign overrun_o  = sample_tick_i & busy_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      voice_q <= '0;
    end else begin
      state_q <= state_d;
      voice_q <= voice_d;
    end
  end

  always_comb begin
    state_d = state_q;
    voice_d = voice_q;
    done_o  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sample_tick_i) begin
          state_d = S_LOAD;
          voice_d = '0;
        end
      end
      S_LOAD: state_d = S_UPDATE;
      S_UPDATE: begin
        if (last_voice) begin
          state_d = S_IDLE;
          done_o  = 1'b1;
        end else begin
          state_d = S_LOAD;
          voice_d = voice_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sel_gate  = 1'b0;
    sel_prev  = 1'b0;
    sel_phase = PH_IDLE;
    sel_cnt   = '0;
    sel_level = '0;
    sel_ad    = '0;
    sel_sr    = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (32'(voice_q) == i) begin
        sel_gate  = control_i[i*8];
        sel_prev  = prev_gate_q[i];
        sel_phase = phase_q[i];
        sel_cnt   = cnt_q[i];
        sel_level = level_q[i];
        sel_ad    = ad_i[i*8 +: 8];
        sel_sr    = sr_i[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stg_gate  <= 1'b0;
      stg_prev  <= 1'b0;
      stg_phase <= PH_IDLE;
      stg_cnt   <= '0;
      stg_level <= '0;
      stg_ad    <= '0;
      stg_sr    <= '0;
    end else if (state_q == S_LOAD) begin
      stg_gate  <= sel_gate;
      stg_prev  <= sel_prev;
      stg_phase <= sel_phase;
      stg_cnt   <= sel_cnt;
      stg_level <= sel_level;
      stg_ad    <= sel_ad;
      stg_sr    <= sel_sr;
    end
  end

  env_step u_step (
    .gate       (stg_gate),
    .prev_gate  (stg_prev),
    .phase      (stg_phase),
    .cnt        (stg_cnt),
    .level      (stg_level),
    .ad         (stg_ad),
    .sr         (stg_sr),
    .phase_next (nxt_phase),
    .cnt_next   (nxt_cnt),
    .level_next (nxt_level)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        phase_q[i]     <= PH_IDLE;
        cnt_q[i]       <= '0;
        level_q[i]     <= '0;
        prev_gate_q[i] <= 1'b0;
      end
    end else if (state_q == S_UPDATE) begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        if (32'(voice_q) == i) begin
          phase_q[i]     <= nxt_phase;
          cnt_q[i]       <= nxt_cnt;
          level_q[i]     <= nxt_level;
          prev_gate_q[i] <= stg_gate;
        end
      end
    end
  end

  // The level flops are written only in the voice's update slot, so they are the envelope output.
  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_env
    assign env_o[g*8 +: 8] = level_q[g];
  end

endmodule

// File: tb/tb_adsr_scheduler.sv
// Randomized bench for adsr_scheduler against a tick-level envelope reference model.
module tb_adsr_scheduler;

  localparam int NV = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            tick;
  logic [NV*8-1:0] control, ad_bus, sr_bus, env;
  logic            busy, done, overrun;
  logic [7:0]      ctl [NV];
  logic [7:0]      ad  [NV];
  logic [7:0]      sr  [NV];

  int errors = 0;
  int checks = 0;
  int done_seen = 0;

  // Reference model: 0 idle, 1 attack, 2 decay/sustain, 3 release.
  int m_ph [NV];
  int m_cnt[NV];
  int m_lvl[NV];
  int m_pg [NV];
  int lut  [16] = '{1, 2, 4, 6, 9, 14, 17, 20, 25, 62, 125, 200, 250, 750, 1250, 2000};

  always #5 clk = ~clk;

  always_comb begin
    control = '0;
    ad_bus  = '0;
    sr_bus  = '0;
    for (int i = 0; i < NV; i++) begin
      control[i*8 +: 8] = ctl[i];
      ad_bus[i*8 +: 8]  = ad[i];
      sr_bus[i*8 +: 8]  = sr[i];
    end
  end

  adsr_scheduler #(.NUM_VOICES(NV)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .sample_tick_i(tick),
    .control_i    (control),
    .ad_i         (ad_bus),
    .sr_i         (sr_bus),
    .env_o        (env),
    .busy_o       (busy),
    .done_o       (done),
    .overrun_o    (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] env_of(input int v);
    return {24'b0, env[v*8 +: 8]};
  endfunction

  function automatic void model_reset();
    for (int v = 0; v < NV; v++) begin
      m_ph[v] = 0; m_cnt[v] = 0; m_lvl[v] = 0; m_pg[v] = 0;
    end
  endfunction

  function automatic void model_tick();
    for (int v = 0; v < NV; v++) begin
      int g, rate;
      g = int'(ctl[v][0]);
      if (g == 1 && m_pg[v] == 0) begin
        m_ph[v] = 1; m_cnt[v] = 0;
      end else if (g == 0 && m_pg[v] == 1 && (m_ph[v] == 1 || m_ph[v] == 2)) begin
        m_ph[v] = 3; m_cnt[v] = 0;
      end else if (m_ph[v] == 0) begin
        m_cnt[v] = 0;
      end else begin
        if (m_ph[v] == 1)      rate = int'(ad[v]) / 16;
        else if (m_ph[v] == 2) rate = int'(ad[v]) % 16;
        else                   rate = int'(sr[v]) % 16;
        if (m_cnt[v] + 1 >= lut[rate]) begin
          m_cnt[v] = 0;
          case (m_ph[v])
            1: begin
              m_lvl[v] = (m_lvl[v] + 1 > 255) ? 255 : m_lvl[v] + 1;
              if (m_lvl[v] == 255) m_ph[v] = 2;
            end
            2: if (m_lvl[v] > (int'(sr[v]) / 16) * 17) m_lvl[v] = m_lvl[v] - 1;
            default: begin
              m_lvl[v] = (m_lvl[v] - 1 < 0) ? 0 : m_lvl[v] - 1;
              if (m_lvl[v] == 0) m_ph[v] = 0;
            end
          endcase
        end else begin
          m_cnt[v] = m_cnt[v] + 1;
        end
      end
      m_pg[v] = g;
    end
  endfunction

  // One accepted tick; every cycle of the sweep is checked against the slot timing.
  task automatic run_tick();
    int old_l[NV];
    int new_l[NV];
    for (int v = 0; v < NV; v++) old_l[v] = m_lvl[v];
    model_tick();
    for (int v = 0; v < NV; v++) new_l[v] = m_lvl[v];
    @(negedge clk); tick = 1'b1; #1;
    check("tick_busy", busy, 0);
    check("tick_overrun", overrun, 0);
    for (int n = 1; n <= 2*NV + 1; n++) begin
      @(negedge clk); tick = 1'b0; #1;
      check("sweep_busy", busy, (n <= 2*NV));
      check("sweep_done", done, (n == 2*NV));
      if (done === 1'b1) done_seen++;
      for (int v = 0; v < NV; v++)
        check("env_slot", env_of(v), (n >= 3 + 2*v) ? new_l[v] : old_l[v]);
    end
  endtask

  task automatic run_ticks(input int k);
    for (int i = 0; i < k; i++) run_tick();
  endtask

  task automatic spaced_ticks(input int sp, input int count);
    int last_acc;
    logic acc;
    last_acc = -1000;
    for (int c = 0; c < sp * count; c++) begin
      @(negedge clk);
      tick = ((c % sp) == 0);
      #1;
      if (tick) begin
        acc = (c - last_acc >= 2*NV + 1);
        if (acc) begin
          last_acc = c;
          model_tick();
        end
        check("overrun", overrun, !acc);
      end
    end
    @(negedge clk); tick = 1'b0;
    repeat (2*NV + 2) @(negedge clk);
    #1;
    for (int v = 0; v < NV; v++) check("spaced_env", env_of(v), m_lvl[v]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    rst_n = 1'b0;
    tick  = 1'b0;
    for (int v = 0; v < NV; v++) begin
      ctl[v] = 8'h00; ad[v] = 8'($urandom); sr[v] = 8'($urandom);
    end
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    for (int v = 0; v < NV; v++) check("reset_env", env_of(v), 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_overrun", overrun, 0);
    @(negedge clk); rst_n = 1'b1;

    // All gates low: nothing moves, one done pulse per tick.
    d0 = done_seen;
    run_ticks(10);
    check("idle_done_count", done_seen - d0, 10);
    for (int v = 0; v < NV; v++) check("idle_env", env_of(v), 0);

    // Fastest attack, decay to sustain 8*17.
    ctl[0] = 8'h01; ad[0] = 8'h00; sr[0] = 8'h80;
    run_tick();      check("attack_first", env_of(0), 0);
    run_ticks(127);  check("attack_mid", env_of(0), 127);
    run_ticks(128);  check("attack_peak", env_of(0), 255);
    run_ticks(119);  check("decay_sustain", env_of(0), 136);
    run_ticks(5);    check("sustain_hold", env_of(0), 136);

    // Release at rate 0 down to zero, then stays.
    ctl[0] = 8'h00;
    run_tick();      check("release_start", env_of(0), 136);
    run_ticks(136);  check("release_zero", env_of(0), 0);
    run_ticks(3);    check("idle_hold", env_of(0), 0);

    // Slow attack (62 ticks per step) on voice 1.
    ctl[1] = 8'h01; ad[1] = 8'h90; sr[1] = 8'hF0;
    run_ticks(186);  check("slow_attack_2", env_of(1), 2);
    run_tick();      check("slow_attack_3", env_of(1), 3);
    check("slow_other_v0", env_of(0), 0);
    check("slow_other_v2", env_of(2), 0);

    // Retrigger from release keeps the current level.
    ctl[2] = 8'h01; ad[2] = 8'h00; sr[2] = 8'h00;
    run_ticks(101);  check("retrig_peak", env_of(2), 100);
    ctl[2] = 8'h00;
    run_tick();      check("retrig_release", env_of(2), 100);
    ctl[2] = 8'h01;
    run_tick();      check("retrig_attack", env_of(2), 100);
    run_tick();      check("retrig_climb", env_of(2), 101);

    // Random register and gate traffic.
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        int v;
        v = $urandom_range(0, NV - 1);
        ctl[v] = 8'($urandom);
        ad[v]  = {4'($urandom_range(0, 4)), 4'($urandom_range(0, 4))};
        sr[v]  = {4'($urandom), 4'($urandom_range(0, 4))};
      end
      run_tick();
    end

    // Ticks closer than a sweep: drops and overrun pulses.
    for (int v = 0; v < NV; v++) begin
      ctl[v] = 8'h01; ad[v] = 8'h11; sr[v] = 8'h41;
    end
    spaced_ticks(4, 12);
    spaced_ticks(6, 10);
    spaced_ticks(7, 8);
    spaced_ticks(9, 8);

    // Reset during voice 1's load slot.
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int v = 0; v < NV; v++) check("midreset_env", env_of(v), 0);
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    run_ticks(3);
    for (int v = 0; v < NV; v++) check("post_reset_env", env_of(v), m_lvl[v]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adsr_scheduler.md
# adsr_scheduler

Time-multiplexed ADSR envelope scheduler for the synth: on every sample tick it walks all voices in order and drives one shared envelope-step datapath, updating per-voice phase, rate counter and 8-bit envelope level from each voice's gate bit and AD/SR registers. It sits between the register file (control/AD/SR bytes) and the controller/mixer, which consume the per-voice envelope levels for amplitude scaling.

## Interface
- `NUM_VOICES`, 3, number of voices scheduled per sample tick (1..16)
- `clk_i`  in  1  system clock
- `rst_ni`  in  1  reset; one clock, reset is asynchronous and active-low
- `sample_tick_i`  in  1  single-cycle sample-rate strobe
- `control_i`  in  NUM_VOICES×8  per-voice control register; bit 0 = gate
- `ad_i`  in  NUM_VOICES×8  [7:4] attack rate, [3:0] decay rate
- `sr_i`  in  NUM_VOICES×8  [7:4] sustain level, [3:0] release rate
- `env_o`  out  NUM_VOICES×8  registered envelope level per voice
- `busy_o`  out  1  high while a sweep is in progress
- `done_o`  out  1  one-cycle pulse when a sweep completes
- `overrun_o`  out  1  one-cycle pulse when `sample_tick_i` arrives while busy

## Operation
- Per-voice state: phase {IDLE, ATTACK, DECAY_SUS, RELEASE}, 11-bit rate counter, 8-bit level, previous gate bit.
- Sweep FSM: S_IDLE -> (tick) S_LOAD(v) -> S_UPDATE(v) -> S_LOAD(v+1) ... -> after S_UPDATE(NUM_VOICES-1) -> S_IDLE with `done_o`.
- S_LOAD: latch voice v's gate, AD, SR, phase, counter, level into the shared stage. S_UPDATE: write next state back and update `env_o[v]`.
- Gate handling (sampled only in the voice's slot):
  - Gate 0->1 from any phase: phase ATTACK, counter cleared, level unchanged, no step this tick.
  - Gate 1->0 from ATTACK or DECAY_SUS: phase RELEASE, counter cleared.
  - Gate held 1 in ATTACK or DECAY_SUS: no retrigger.
- Rate step: period P = RATE_LUT[rate]; counter+1 >= P clears the counter and applies one step, otherwise the counter increments.
  - ATTACK: level+1. On reaching 255, phase becomes DECAY_SUS in the same update.
  - DECAY_SUS: level-1 only while level > S×17. Level at or below sustain holds, with no upward move.
  - RELEASE: level-1. On reaching 0, phase becomes IDLE.
  - IDLE: counter is held at 0.
- RATE_LUT in ticks per step = {1,2,4,6,9,14,17,20,25,62,125,200,250,750,1250,2000}.
- Level saturates at 0..255 and never wraps.
- Register changes to AD/SR mid-phase take effect at the voice's next slot. The counter is not cleared, but the P compare uses the new rate.

## Timing
- Reset: all phases IDLE, counters 0, levels 0, prev gates 0, `env_o` all 0, `busy_o`/`done_o`/`overrun_o` 0, FSM S_IDLE.
- Tick sampled at cycle t:
  - `busy_o` high from t+1.
  - `env_o[v]` updated at the end of cycle t+2+2v.
  - `done_o` pulses at t+2·NUM_VOICES, the cycle of the last S_UPDATE; `busy_o` low from the following cycle.
- A sweep takes 2·NUM_VOICES cycles, so ticks must be at least 2·NUM_VOICES+1 cycles apart.
- A tick while busy is dropped (no queuing), with `overrun_o` pulsing that cycle.
- A tick in the same cycle as `done_o` counts as busy and is dropped.
- Reset asserted mid-sweep: immediate return to reset state; the partially updated voices are lost.

## Structure
- Package `env_pkg`: phase enum `env_phase_e`, `RATE_LUT` constant array, `RATE_CNT_W`=11, `sustain_level(s)` function returning s×17.
- Sub-module `env_step`: purely combinational next-state unit taking {gate, prev_gate, phase, counter, level, ad, sr} and returning {phase, counter, level}. It is instanced once and shared by all voices.
- Per-voice state lives in flop arrays inside `adsr_scheduler`.

## Test plan
- Reset, then 10 ticks with all gates 0 -> `env_o`=0 for all voices, phases IDLE, 10 `done_o` pulses, no `overrun_o`.
- Voice 0 with AD=0x00, SR=0x80, gate 1 -> after tick k `env_o[0]`=k−1 for k≤256; reaches 255; then decays to 136 after 119 further ticks and holds there.
- Gate 0 on voice 0 at level 136 with release rate 0 -> reaches 0 after 136 ticks, then IDLE; extra ticks keep 0.
- Attack rate 9 (P=62) on voice 1 -> level increments exactly every 62 ticks; voices 0/2 unchanged.
- Retrigger: gate 1->0->1 across ticks during RELEASE at level 100 -> ATTACK resumes from 100, not 0.
- Tick spacing 4 cycles with NUM_VOICES=3 -> alternate ticks dropped, `overrun_o` pulses, state matches a model fed only the accepted ticks.
- Assert `rst_ni` low during voice 1's slot -> all outputs 0 next cycle; the next sweep starts cleanly from IDLE.
